// File: rtl/pool_frame_rx.sv
// Captures one ROWS x COLS pooled feature map from the video-style pixel stream and
// replays it in raster order over a valid/ready stream.
module pool_frame_rx #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned COLS   = 12,
    parameter int unsigned ROWS   = 12,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              cal_start,
    input  logic [DATA_W-1:0] pool_data,
    input  logic              pool_data_vld,
    input  logic              active_video,
    input  logic              vid_ce,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_last,
    output logic              frame_done,
    output logic              err_ovf
);

    localparam int unsigned       Depth    = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);
    localparam logic [ADDR_W-1:0] LastCol  = ADDR_W'(COLS - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
    logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_W:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              pf_vld_q, pf_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_vld_q, out_vld_d;
    logic              frame_done_q, frame_done_d;
    logic              err_ovf_q, err_ovf_d;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] mem_rdata;

    logic acc, hs, pf_move, ren, we;

    assign acc     = pool_data_vld & active_video & vid_ce;
    assign hs      = out_vld_q & out_rdy;
    // Prefetched word may enter the output register when it is empty or emptying.
    assign pf_move = pf_vld_q & (~out_vld_q | out_rdy);
    assign ren     = (state_q == StDrain) & (raddr_q < (ADDR_W + 1)'(Depth))
                   & (~pf_vld_q | pf_move);
    assign we      = (state_q == StCapture) & acc & ~cal_start;

    always_ff @(posedge sclk) begin
        if (we) begin
            mem[wr_cnt_q] <= pool_data;
        end
        if (ren) begin
            mem_rdata <= mem[raddr_q[ADDR_W-1:0]];
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        raddr_d      = raddr_q;
        rd_cnt_d     = rd_cnt_q;
        pf_vld_d     = pf_vld_q;
        out_data_d   = out_data_q;
        out_vld_d    = out_vld_q;
        frame_done_d = 1'b0;
        err_ovf_d    = err_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (acc) err_ovf_d = 1'b1;
            end
            StCapture: begin
                if (acc) begin
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (col_cnt_q == LastCol) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + ADDR_W'(1);
                    end else begin
                        col_cnt_d = col_cnt_q + ADDR_W'(1);
                    end
                    if (wr_cnt_q == LastAddr) begin
                        state_d  = StDrain;
                        raddr_d  = '0;
                        rd_cnt_d = '0;
                        pf_vld_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                if (acc) err_ovf_d = 1'b1;
                if (ren) raddr_d = raddr_q + (ADDR_W + 1)'(1);
                pf_vld_d = ren | (pf_vld_q & ~pf_move);
                if (pf_move) begin
                    out_data_d = mem_rdata;
                    out_vld_d  = 1'b1;
                end else if (hs) begin
                    out_vld_d = 1'b0;
                end
                if (hs) begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    if (rd_cnt_q == LastAddr) begin
                        state_d      = StIdle;
                        out_vld_d    = 1'b0;
                        pf_vld_d     = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Start pulse overrides everything, including a coincident pixel.
        if (cal_start) begin
            state_d      = StCapture;
            wr_cnt_d     = '0;
            col_cnt_d    = '0;
            row_cnt_d    = '0;
            raddr_d      = '0;
            rd_cnt_d     = '0;
            pf_vld_d     = 1'b0;
            out_vld_d    = 1'b0;
            frame_done_d = 1'b0;
            err_ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= StIdle;
            wr_cnt_q     <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            raddr_q      <= '0;
            rd_cnt_q     <= '0;
            pf_vld_q     <= 1'b0;
            out_data_q   <= '0;
            out_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            raddr_q      <= raddr_d;
            rd_cnt_q     <= rd_cnt_d;
            pf_vld_q     <= pf_vld_d;
            out_data_q   <= out_data_d;
            out_vld_q    <= out_vld_d;
            frame_done_q <= frame_done_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_vld    = out_vld_q;
    assign out_last   = out_vld_q & (rd_cnt_q == LastAddr);
    assign frame_done = frame_done_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_pool_frame_rx.sv
// Directed bench for pool_frame_rx: expected pixels are queued as they are sent and
// compared against each accepted output word.
module tb_pool_frame_rx;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        cal_start = 1'b0;
    logic [31:0] pool_data = '0;
    logic        pool_data_vld = 1'b0;
    logic        active_video = 1'b0;
    logic        vid_ce = 1'b0;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic        out_last;
    logic        frame_done;
    logic        err_ovf;

    pool_frame_rx #(.DATA_W(32), .COLS(12), .ROWS(12), .ADDR_W(8)) dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .cal_start     (cal_start),
        .pool_data     (pool_data),
        .pool_data_vld (pool_data_vld),
        .active_video  (active_video),
        .vid_ce        (vid_ce),
        .out_data      (out_data),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_last      (out_last),
        .frame_done    (frame_done),
        .err_ovf       (err_ovf)
    );

    always #5 sclk = ~sclk;

    int          total = 0;
    int          passed = 0;
    logic [31:0] exp_q[$];
    int          widx = 0;
    int          fd_cnt = 0;
    int          cyc = 0;
    int          hs_first = 0;
    int          hs_last = 0;
    bit          rnd_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Ready pattern: constant 1 or random, changed just after each rising edge.
    initial forever begin
        @(posedge sclk);
        #1;
        out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: sampled on the falling edge, when outputs and out_rdy are stable.
    always @(negedge sclk) begin
        logic [31:0] e;
        cyc++;
        if (!s_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (prev_stall) begin
                chk("hold_vld", 32'(out_vld), 32'd1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_vld && exp_q.size() == 0) begin
                chk("spurious_vld", 32'(out_vld), 32'd0);
            end else if (out_vld && out_rdy) begin
                e = exp_q.pop_front();
                chk("data", out_data, e);
                chk("last", 32'(out_last), 32'(exp_q.size() == 0));
                if (widx == 0) hs_first = cyc;
                hs_last = cyc;
                widx++;
            end
            prev_stall = out_vld && !out_rdy;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic pulse_cal();
        cal_start = 1'b1;
        @(posedge sclk);
        #1;
        cal_start = 1'b0;
        exp_q.delete();
        widx = 0;
    endtask

    task automatic drive_pix(input logic [31:0] v, input bit a, input bit c);
        pool_data     = v;
        pool_data_vld = 1'b1;
        active_video  = a;
        vid_ce        = c;
        @(posedge sclk);
        #1;
        pool_data_vld = 1'b0;
        active_video  = 1'b0;
        vid_ce        = 1'b0;
    endtask

    // Sends cnt pixels base..base+cnt-1 with random gaps; noise adds disqualified strobes.
    task automatic send_pixels(input int base, input int cnt, input bit noise);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge sclk);
                #1;
            end
            if (noise) begin
                drive_pix(32'd999, 1'b0, 1'b1);
                drive_pix(32'd999, 1'b1, 1'b0);
            end
            exp_q.push_back(32'(base + i));
            drive_pix(32'(base + i), 1'b1, 1'b1);
        end
    endtask

    // Right after the final write edge: out_vld must rise two edges later.
    task automatic check_latency();
        @(negedge sclk);
        chk("lat_vld_c0", 32'(out_vld), 32'd0);
        @(negedge sclk);
        chk("lat_vld_c1", 32'(out_vld), 32'd0);
        @(negedge sclk);
        chk("lat_vld_c2", 32'(out_vld), 32'd1);
    endtask

    task automatic wait_drain(input int fd_before);
        int c;
        for (c = 0; c < 3000 && (exp_q.size() != 0 || out_vld); c++) @(negedge sclk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge sclk);
        chk("frame_done_cnt", 32'(fd_cnt), 32'(fd_before + 1));
        chk("idle_vld", 32'(out_vld), 32'd0);
        @(posedge sclk);
        #1;
    endtask

    task automatic full_frame(input int base, input bit noise);
        int fd0;
        fd0 = fd_cnt;
        pulse_cal();
        send_pixels(base, 144, noise);
        check_latency();
        wait_drain(fd0);
    endtask

    initial begin
        #12;
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err_ovf), 32'd0);
        s_rst_n = 1'b1;
        @(posedge sclk);
        #1;

        // Base frame at full rate.
        rnd_rdy = 1'b0;
        full_frame(0, 1'b0);
        chk("full_rate_span", 32'(hs_last - hs_first), 32'd143);
        chk("t1_err", 32'(err_ovf), 32'd0);

        // Backpressure.
        rnd_rdy = 1'b1;
        full_frame(0, 1'b0);
        rnd_rdy = 1'b0;

        // Qualifier filtering.
        full_frame(0, 1'b1);
        chk("t3_err", 32'(err_ovf), 32'd0);

        // Mid-frame abort.
        pulse_cal();
        send_pixels(0, 50, 1'b0);
        full_frame(1000, 1'b0);
        chk("t4_err", 32'(err_ovf), 32'd0);

        // Overrun during drain.
        begin
            int fd0;
            fd0 = fd_cnt;
            pulse_cal();
            send_pixels(0, 144, 1'b0);
            check_latency();
            @(posedge sclk);
            #1;
            drive_pix(32'd777, 1'b1, 1'b1);
            @(negedge sclk);
            chk("ovf_set", 32'(err_ovf), 32'd1);
            wait_drain(fd0);
            chk("ovf_sticky", 32'(err_ovf), 32'd1);
        end
        pulse_cal();
        @(negedge sclk);
        chk("ovf_clear", 32'(err_ovf), 32'd0);
        @(posedge sclk);
        #1;

        // Reset mid-drain.
        begin
            int c;
            pulse_cal();
            send_pixels(0, 144, 1'b0);
            for (c = 0; c < 1000 && widx < 70; c++) @(negedge sclk);
            chk("reach_word70", 32'(widx >= 70), 32'd1);
            #2;
            s_rst_n = 1'b0;
            exp_q.delete();
            #1;
            chk("mid_rst_vld", 32'(out_vld), 32'd0);
            chk("mid_rst_data", out_data, 32'd0);
            chk("mid_rst_last", 32'(out_last), 32'd0);
            #4;
            s_rst_n = 1'b1;
            repeat (200) @(negedge sclk);
            chk("post_rst_vld", 32'(out_vld), 32'd0);
            @(posedge sclk);
            #1;
        end
        full_frame(2000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
